// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, decode handshake and execute redirect.
// The misalign_err signal exists only when IFU_MISALIGN_TRAP_EN is defined.
interface instr_fetch_unit_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_rvalid;
    logic [31:0]         imem_rdata;
    logic                instr_valid;
    logic                instr_ready;
    logic [31:0]         instr;
    logic [6:0]          opcode;
    logic [PC_WIDTH-1:0] pc;
    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_pc;
`ifdef IFU_MISALIGN_TRAP_EN
    logic                misalign_err;
`endif

    modport master (
        output imem_req, imem_addr, instr_valid, instr, opcode, pc,
`ifdef IFU_MISALIGN_TRAP_EN
        output misalign_err,
`endif
        input  imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, opcode, pc,
`ifdef IFU_MISALIGN_TRAP_EN
        input  misalign_err,
`endif
        output imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single outstanding imem request, instruction register, decode handshake.
// Optional IFU_MISALIGN_TRAP_EN: misaligned redirect raises sticky misalign_err and parks fetch in IDLE.
module instr_fetch_unit #(
    parameter int unsigned          PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
    parameter logic [31:0]          NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic                kill_q, kill_d;
    logic [PC_WIDTH-1:0] redirect_tgt_c;
    logic                imem_req_c;
    logic                instr_valid_c;

`ifdef IFU_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    logic bad_redirect_c;
    assign bad_redirect_c = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
    assign redirect_tgt_c = bus.redirect_pc;
`else
    assign redirect_tgt_c = bus.redirect_pc & ~PC_WIDTH'(3);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            kill_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            kill_q  <= kill_d;
        end
    end

`ifdef IFU_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`endif

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        kill_d  = kill_q;
`ifdef IFU_MISALIGN_TRAP_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (bus.redirect) pc_d = redirect_tgt_c;
            end
            REQ: begin
                state_d = WAIT;
                if (bus.redirect) begin
                    pc_d   = redirect_tgt_c;
                    kill_d = 1'b1;
                end
            end
            WAIT: begin
                // A redirect that coincides with rvalid consumes that response itself
                if (bus.redirect) begin
                    pc_d = redirect_tgt_c;
                    if (bus.imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (bus.imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_d = bus.imem_rdata;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.redirect) begin
                    pc_d    = redirect_tgt_c;
                    instr_d = NOP_INSTR;
                    state_d = REQ;
                end else if (bus.instr_ready) begin
                    pc_d    = pc_q + PC_WIDTH'(4);
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef IFU_MISALIGN_TRAP_EN
        if (bad_redirect_c) begin
            pc_d       = pc_q;
            instr_d    = instr_q;
            kill_d     = 1'b0;
            misalign_d = 1'b1;
            state_d    = IDLE;
        end
        if (misalign_q) state_d = IDLE;
`endif
    end

    // Moore outputs decoded from the state register
    always_comb begin
        imem_req_c    = 1'b0;
        instr_valid_c = 1'b0;
        case (state_q)
            REQ:     imem_req_c    = 1'b1;
            HOLD:    instr_valid_c = 1'b1;
            default: ;
        endcase
    end

    assign bus.imem_req    = imem_req_c;
    assign bus.instr_valid = instr_valid_c;
    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[6:0];
`ifdef IFU_MISALIGN_TRAP_EN
    assign bus.misalign_err = misalign_q;
`endif

endmodule
